// File: rtl/cpu_phase_seq.sv
// Instruction-cycle sequencer: turns each phase-strobe frame into one fetch/decode/execute/
// writeback pass, with fetch handshake, stall counting and phase-order checking.
module cpu_phase_seq #(
    parameter int unsigned NPH      = 15,
    parameter int unsigned AW       = 8,
    parameter int unsigned PH_FETCH = 0,
    parameter int unsigned PH_DEC   = 4,
    parameter int unsigned PH_EXEC  = 8,
    parameter int unsigned PH_WB    = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NPH-1:0] phase,
    input  logic           halt_req,
    input  logic           mem_ack,
    input  logic [7:0]     mem_rdata,
    output logic           mem_req,
    output logic [AW-1:0]  mem_addr,
    output logic [7:0]     ir,
    output logic [AW-1:0]  pc,
    output logic           decode_en,
    output logic           exec_en,
    output logic           wb_en,
    output logic           busy,
    output logic           halted,
    output logic [7:0]     stall_cnt,
    output logic           phase_err
);

    localparam int unsigned IW = $clog2(NPH);

    typedef enum logic [2:0] {
        StWaitFrame,
        StFetch,
        StReady,
        StExecWait,
        StWbWait,
        StHalted
    } state_e;

    state_e        state;
    logic [IW-1:0] prev_idx;
    logic          prev_valid;

    logic          strobe;
    logic          multi;
    logic [IW-1:0] strobe_idx;
    logic          order_err;
    logic          seq_err;
    logic          ph_ok;
    logic          ph_fetch;
    logic          ph_dec;
    logic          ph_exec;
    logic          ph_wb;

    always_comb begin
        strobe     = |phase;
        multi      = $countones(phase) > 1;
        strobe_idx = '0;
        for (int i = 0; i < NPH; i++) begin
            if (phase[i]) strobe_idx = IW'(i);
        end
        // phase[0] always restarts the ordering, so it can never be out of order.
        order_err = strobe && !multi && (strobe_idx != '0) && prev_valid &&
                    (strobe_idx <= prev_idx);
        seq_err   = multi || order_err;
        ph_ok     = strobe && !seq_err;
        ph_fetch  = ph_ok && phase[PH_FETCH];
        ph_dec    = ph_ok && phase[PH_DEC];
        ph_exec   = ph_ok && phase[PH_EXEC];
        ph_wb     = ph_ok && phase[PH_WB];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StWaitFrame;
            prev_idx   <= '0;
            prev_valid <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir         <= '0;
            pc         <= '0;
            decode_en  <= 1'b0;
            exec_en    <= 1'b0;
            wb_en      <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            stall_cnt  <= '0;
            phase_err  <= 1'b0;
        end else begin
            decode_en <= 1'b0;
            exec_en   <= 1'b0;
            wb_en     <= 1'b0;
            // busy stays up through the writeback clock and falls right after it.
            if (wb_en) busy <= 1'b0;

            if (strobe) begin
                if (seq_err) begin
                    prev_valid <= 1'b0;
                end else begin
                    prev_valid <= 1'b1;
                    prev_idx   <= strobe_idx;
                end
            end

            if (seq_err) begin
                phase_err <= 1'b1;
                mem_req   <= 1'b0;
                busy      <= 1'b0;
                halted    <= 1'b0;
                state     <= StWaitFrame;
            end else begin
                case (state)
                    StWaitFrame, StHalted: begin
                        if (ph_fetch) begin
                            if (halt_req) begin
                                halted <= 1'b1;
                                state  <= StHalted;
                            end else begin
                                halted   <= 1'b0;
                                mem_req  <= 1'b1;
                                mem_addr <= pc;
                                busy     <= 1'b1;
                                state    <= StFetch;
                            end
                        end
                    end
                    StFetch: begin
                        if (mem_ack) begin
                            ir      <= mem_rdata;
                            mem_req <= 1'b0;
                            if (ph_dec) begin
                                decode_en <= 1'b1;
                                state     <= StExecWait;
                            end else begin
                                state <= StReady;
                            end
                        end else if (ph_dec) begin
                            // Fetch deadline missed: the frame is voided.
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            if (stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
                            state   <= StWaitFrame;
                        end
                    end
                    StReady: begin
                        if (ph_dec) begin
                            decode_en <= 1'b1;
                            state     <= StExecWait;
                        end
                    end
                    StExecWait: begin
                        if (ph_exec) begin
                            exec_en <= 1'b1;
                            state   <= StWbWait;
                        end
                    end
                    StWbWait: begin
                        if (ph_wb) begin
                            wb_en <= 1'b1;
                            pc    <= pc + AW'(1);
                            state <= StWaitFrame;
                        end
                    end
                    default: state <= StWaitFrame;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Directed bench for cpu_phase_seq: drives 30-clk phase frames and checks responses.
module tb_cpu_phase_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] phase = '0;
    logic        halt_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [7:0]  ir;
    logic [7:0]  pc;
    logic        decode_en;
    logic        exec_en;
    logic        wb_en;
    logic        busy;
    logic        halted;
    logic [7:0]  stall_cnt;
    logic        phase_err;

    int checks = 0;
    int errors = 0;

    // Per-frame observations.
    int          n_dec, n_exec, n_wb, t_dec, t_exec, t_wb, n_req;
    logic        req_c0, req_c7, req_c8, busy_c24, busy_c25, halted_c0;
    logic [7:0]  addr_c0;

    cpu_phase_seq dut (
        .clk       (clk),
        .reset     (reset),
        .phase     (phase),
        .halt_req  (halt_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .ir        (ir),
        .pc        (pc),
        .decode_en (decode_en),
        .exec_en   (exec_en),
        .wb_en     (wb_en),
        .busy      (busy),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .phase_err (phase_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: normal order; 1: bits 3 and 5 together; 2: phase[8] then phase[6].
    task automatic frame(input int ack_clk, input logic [7:0] rdata, input logic halt,
                         input int mode);
        n_dec = 0; n_exec = 0; n_wb = 0; t_dec = -1; t_exec = -1; t_wb = -1; n_req = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            phase = '0;
            if (c % 2 == 0) phase[c/2] = 1'b1;
            if (mode == 1 && c == 6) phase[5] = 1'b1;
            if (mode == 2 && c == 12) phase = 15'h0100;
            if (mode == 2 && c == 16) phase = 15'h0040;
            halt_req  = halt;
            mem_ack   = (c == ack_clk);
            mem_rdata = rdata;
            @(posedge clk);
            #1;
            if (decode_en) begin n_dec++; if (t_dec < 0) t_dec = c; end
            if (exec_en)   begin n_exec++; if (t_exec < 0) t_exec = c; end
            if (wb_en)     begin n_wb++; if (t_wb < 0) t_wb = c; end
            if (mem_req) n_req++;
            if (c == 0) begin req_c0 = mem_req; addr_c0 = mem_addr; halted_c0 = halted; end
            if (c == 7) req_c7 = mem_req;
            if (c == 8) req_c8 = mem_req;
            if (c == 24) busy_c24 = busy;
            if (c == 25) busy_c25 = busy;
        end
        @(negedge clk);
        phase = '0; mem_ack = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_phase_err", 32'(phase_err), 0);
        reset = 1'b0;

        // Normal frame: ack 3 clk after phase[0].
        frame(3, 8'hA5, 1'b0, 0);
        chk("a_req_c0", 32'(req_c0), 1);
        chk("a_addr_c0", 32'(addr_c0), 0);
        chk("a_ir", 32'(ir), 32'hA5);
        chk("a_t_dec", 32'(t_dec), 8);
        chk("a_t_exec", 32'(t_exec), 16);
        chk("a_t_wb", 32'(t_wb), 24);
        chk("a_n_pulses", 32'(n_dec + n_exec + n_wb), 3);
        chk("a_busy_c24", 32'(busy_c24), 1);
        chk("a_busy_c25", 32'(busy_c25), 0);
        chk("a_pc", 32'(pc), 1);

        // No ack: frame voided at the decode deadline.
        frame(-1, 8'h77, 1'b0, 0);
        chk("b_req_c7", 32'(req_c7), 1);
        chk("b_req_c8", 32'(req_c8), 0);
        chk("b_stall", 32'(stall_cnt), 1);
        chk("b_pulses", 32'(n_dec + n_exec + n_wb), 0);
        chk("b_pc", 32'(pc), 1);
        chk("b_ir", 32'(ir), 32'hA5);

        // Ack on the same clk as phase[4]: ack wins.
        frame(8, 8'h3C, 1'b0, 0);
        chk("c_addr_c0", 32'(addr_c0), 1);
        chk("c_ir", 32'(ir), 32'h3C);
        chk("c_t_dec", 32'(t_dec), 8);
        chk("c_t_wb", 32'(t_wb), 24);
        chk("c_pc", 32'(pc), 2);
        chk("c_stall", 32'(stall_cnt), 1);

        // Walk pc to 0xFF, then wrap.
        for (int f = 0; f < 253; f++) frame(5, 8'h11, 1'b0, 0);
        chk("d_pc_ff", 32'(pc), 32'hFF);
        frame(2, 8'h11, 1'b0, 0);
        chk("d_addr_ff", 32'(addr_c0), 32'hFF);
        chk("d_pc_wrap", 32'(pc), 0);

        // Halt, stay halted, then resume; acks while halted are ignored.
        frame(3, 8'hEE, 1'b1, 0);
        chk("h_halted_c0", 32'(halted_c0), 1);
        chk("h_no_req", 32'(n_req), 0);
        chk("h_pulses", 32'(n_dec + n_exec + n_wb), 0);
        chk("h_ir", 32'(ir), 32'h11);
        frame(3, 8'hEE, 1'b1, 0);
        chk("h2_halted", 32'(halted), 1);
        chk("h2_pc", 32'(pc), 0);
        frame(3, 8'h5A, 1'b0, 0);
        chk("h3_halted_c0", 32'(halted_c0), 0);
        chk("h3_req_c0", 32'(req_c0), 1);
        chk("h3_ir", 32'(ir), 32'h5A);
        chk("h3_pc", 32'(pc), 1);

        // Two strobes at once.
        frame(3, 8'h66, 1'b0, 1);
        chk("e1_err", 32'(phase_err), 1);
        chk("e1_pulses", 32'(n_dec + n_exec + n_wb), 0);
        chk("e1_pc", 32'(pc), 1);
        // Normal frame keeps the sticky error and still runs.
        frame(3, 8'h67, 1'b0, 0);
        chk("e1n_err", 32'(phase_err), 1);
        chk("e1n_wb", 32'(n_wb), 1);
        chk("e1n_pc", 32'(pc), 2);
        // Out-of-order strobe (8 then 6): exec already issued, writeback suppressed.
        frame(3, 8'h68, 1'b0, 2);
        chk("e2_err", 32'(phase_err), 1);
        chk("e2_exec", 32'(n_exec), 1);
        chk("e2_wb", 32'(n_wb), 0);
        chk("e2_pc", 32'(pc), 2);
        chk("e2_ir", 32'(ir), 32'h68);

        // Reset asserted mid-fetch.
        @(negedge clk); phase = 15'h0001;
        @(negedge clk); phase = '0;
        chk("r_req_before", 32'(mem_req), 1);
        reset = 1'b1;
        #1;
        chk("r_req", 32'(mem_req), 0);
        chk("r_pc", 32'(pc), 0);
        chk("r_ir", 32'(ir), 0);
        chk("r_err", 32'(phase_err), 0);
        chk("r_stall", 32'(stall_cnt), 0);
        @(negedge clk); reset = 1'b0;

        // Stall counter saturation.
        for (int f = 0; f < 256; f++) frame(-1, 8'h00, 1'b0, 0);
        chk("s_stall_sat", 32'(stall_cnt), 32'hFF);
        chk("s_pc", 32'(pc), 0);
        frame(4, 8'h99, 1'b0, 0);
        chk("s_addr_c0", 32'(addr_c0), 0);
        chk("s_ir", 32'(ir), 32'h99);
        chk("s_pc_after", 32'(pc), 1);
        chk("s_stall_after", 32'(stall_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
